// File: rtl/wb_regbank.sv
// wb_regbank: pipelined Wishbone B4 slave register bank.
//
// Exposes NUM_RW read/write 32-bit control registers at word addresses
// 0..NUM_RW-1 and NUM_RO read-only status registers at
// NUM_RW..NUM_RW+NUM_RO-1. Every accepted transfer is acknowledged exactly one
// cycle later, so a back-to-back stream completes at one word per clock.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_wb_cyc, i_wb_stb   bus cycle / request strobe (accept = cyc & stb)
//   o_wb_stall           tied to 0
//   o_wb_ack             acknowledge, one cycle after acceptance
//   i_wb_we              1 = write, 0 = read
//   i_wb_addr            word address
//   i_wb_data, i_wb_sel  write data and byte enables
//   o_wb_data            read data, valid while o_wb_ack = 1
//   o_rw_regs            RW register contents, reg k at [32k+31:32k]
//   o_rw_wstb            one-cycle pulse per RW register written
//   i_ro_regs            status inputs, reg j at [32j+31:32j]
//   o_ro_rstb            one-cycle pulse per RO register read
module wb_regbank #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 4,
    parameter logic [NUM_RW*32-1:0] RW_RESET = {NUM_RW*32{1'b0}}
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    output logic                   o_wb_stall,
    output logic                   o_wb_ack,
    input  logic                   i_wb_we,
    input  logic [ADDR_WIDTH-1:0]  i_wb_addr,
    input  logic [31:0]            i_wb_data,
    input  logic [3:0]             i_wb_sel,
    output logic [31:0]            o_wb_data,
    output logic [NUM_RW*32-1:0]   o_rw_regs,
    output logic [NUM_RW-1:0]      o_rw_wstb,
    input  logic [NUM_RO*32-1:0]   i_ro_regs,
    output logic [NUM_RO-1:0]      o_ro_rstb
);

    logic                 acc;
    int                   addr_i;
    logic                 ack_q, ack_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [NUM_RW*32-1:0] rw_regs_q, rw_regs_d;
    logic [NUM_RW-1:0]    wstb_q, wstb_d;
    logic [NUM_RO-1:0]    rstb_q, rstb_d;

    always_comb begin
        acc       = i_wb_cyc & i_wb_stb;
        addr_i    = int'(i_wb_addr);
        ack_d     = acc;
        rdata_d   = rdata_q;
        rw_regs_d = rw_regs_q;
        wstb_d    = '0;
        rstb_d    = '0;
        if (acc) begin
            if (i_wb_we) begin
                // Strobe pulses on any write to an RW register, even with sel=0.
                for (int k = 0; k < NUM_RW; k++) begin
                    if (addr_i == k) begin
                        wstb_d[k] = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (i_wb_sel[b])
                                rw_regs_d[k*32 + b*8 +: 8] = i_wb_data[b*8 +: 8];
                        end
                    end
                end
            end else begin
                // Unmapped reads return zero; reads see the pre-edge register value.
                rdata_d = '0;
                for (int k = 0; k < NUM_RW; k++) begin
                    if (addr_i == k)
                        rdata_d = rw_regs_q[k*32 +: 32];
                end
                for (int j = 0; j < NUM_RO; j++) begin
                    if (addr_i == NUM_RW + j) begin
                        rdata_d   = i_ro_regs[j*32 +: 32];
                        rstb_d[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            rw_regs_q <= RW_RESET;
            wstb_q    <= '0;
            rstb_q    <= '0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            rw_regs_q <= rw_regs_d;
            wstb_q    <= wstb_d;
            rstb_q    <= rstb_d;
        end
    end

    // A master that drops cyc after acceptance aborts the ack; strobes still
    // fire because the side effect has already happened.
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign o_rw_regs  = rw_regs_q;
    assign o_rw_wstb  = wstb_q;
    assign o_ro_rstb  = rstb_q;

endmodule
